// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_pkg
// Description : Shared types and sizes for the sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

    localparam int BIN_W       = 8;
    localparam int BCD_DIGITS  = 3;
    localparam int BCD_W       = 4 * BCD_DIGITS;
    localparam int SHIFT_CNT_W = 3;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd
// Description : Free-running 8-bit binary to 3-digit packed BCD converter,
//               one result every 10 clocks (LOAD, 8 x SHIFT, DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd
    import bin_to_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid
);

    state_e                 state_q, state_d;
    logic [BIN_W-1:0]       bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]       scratch_q, scratch_d;
    logic [BCD_W-1:0]       scratch_adj;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   bcd_valid_q, bcd_valid_d;

    generate
        for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .digit_i (scratch_q[4*g +: 4]),
                .digit_o (scratch_adj[4*g +: 4])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        bin_sr_d    = bin_sr_q;
        scratch_d   = scratch_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        case (state_q)
            LOAD: begin
                bin_sr_d  = bin;
                scratch_d = '0;
                cnt_d     = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                // Corrected digits and remaining binary shift as one wide register.
                {scratch_d, bin_sr_d} = {scratch_adj, bin_sr_q} << 1;
                cnt_d = cnt_q + SHIFT_CNT_W'(1);
                if (cnt_q == SHIFT_CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d       = scratch_q;
                bcd_valid_d = 1'b1;
                state_d     = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            bin_sr_q    <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_sr_q    <= bin_sr_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_bcd
// Description : Self-checking bench for bin_to_bcd: cycle model plus directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

    logic        clk;
    logic        rst_n;
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        bcd_valid;

    int checks = 0;
    int errors = 0;

    bin_to_bcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (bin),
        .bcd       (bcd),
        .bcd_valid (bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a result is due every 10 clocks, sampled on the first edge after reset.
    int          m_phase;
    logic [7:0]  m_sample;
    logic [11:0] m_exp_bcd;
    logic        m_exp_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase     <= 0;
            m_sample    <= '0;
            m_exp_bcd   <= '0;
            m_exp_valid <= 1'b0;
        end else begin
            if (m_phase == 0) m_sample <= bin;
            m_exp_valid <= (m_phase == 9);
            if (m_phase == 9) m_exp_bcd <= to_bcd(int'(m_sample));
            m_phase <= (m_phase == 9) ? 0 : m_phase + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_bcd", bcd, m_exp_bcd);
        chk("model_valid", {11'd0, bcd_valid}, {11'd0, m_exp_valid});
    end

    // Returns at the negedge of the next bcd_valid pulse (the LOAD cycle).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            cycles++;
            if (bcd_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_valid: no pulse within 25 clks, got 0 expected 1");
    endtask

    int n;
    int bnd_in  [6] = '{0, 9, 10, 99, 100, 255};
    logic [11:0] bnd_exp [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};

    initial begin
        rst_n = 1'b0;
        bin   = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_bcd", bcd, 12'h000);
        chk("reset_valid", {11'd0, bcd_valid}, 12'h000);
        rst_n = 1'b1;

        bin = 8'b0001_1001;
        wait_valid(n);
        chk("first_latency", 12'(n), 12'd10);
        chk("bin25_a", bcd, 12'h025);
        wait_valid(n);
        chk("period", 12'(n), 12'd10);
        chk("bin25_b", bcd, 12'h025);

        bin = 8'd78;
        wait_valid(n);
        chk("bin78", bcd, 12'h078);
        wait_valid(n);
        chk("bin78_hold", bcd, 12'h078);

        for (int i = 0; i < 6; i++) begin
            bin = 8'(bnd_in[i]);
            wait_valid(n);
            chk($sformatf("boundary_%0d", bnd_in[i]), bcd, bnd_exp[i]);
        end

        // bin changes two clocks after the LOAD edge must not affect the running conversion.
        bin = 8'd5;
        wait_valid(n);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bin = 8'd200;
        wait_valid(n);
        chk("late_change_old", bcd, 12'h005);
        wait_valid(n);
        chk("late_change_new", bcd, 12'h200);

        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", bcd, 12'h000);
        chk("async_rst_valid", {11'd0, bcd_valid}, 12'h000);
        bin = 8'd123;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(n);
        chk("post_rst_latency", 12'(n), 12'd10);
        chk("post_rst_value", bcd, 12'h123);

        for (int v = 0; v < 256; v++) begin
            bin = 8'(v);
            wait_valid(n);
            chk($sformatf("sweep_%0d", v), bcd, to_bcd(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
